// File: rtl/pkt_arbiter_if.sv
// pkt_arbiter_if: source, sink and status signals of the two-channel packet arbiter.
interface pkt_arbiter_if #(parameter int CNT_W = 8);
  logic [1:0] ch_en;
  logic [1:0] in_rdy;
  logic [1:0] in_acpt;
  logic [7:0] in_data0;
  logic [7:0] in_data1;
  logic out_rdy;
  logic out_acpt;
  logic [7:0] out_data;
  logic [1:0] grant;
  logic busy;
  logic pkt_done;
  logic [CNT_W-1:0] drop_cnt;
  modport master (
    output ch_en, in_rdy, in_data0, in_data1, out_acpt,
    input in_acpt, out_rdy, out_data, grant, busy, pkt_done, drop_cnt
  );
  modport slave (
    input ch_en, in_rdy, in_data0, in_data1, out_acpt,
    output in_acpt, out_rdy, out_data, grant, busy, pkt_done, drop_cnt
  );
endinterface

// File: rtl/pkt_arbiter.sv
// pkt_arbiter: round-robin packet arbiter, sync-aligned, PKT_LEN bytes per grant.
module pkt_arbiter #(
  parameter int PKT_LEN = 204,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset_n,
  pkt_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DROP, FWD} state_t;
  state_t state, state_n;
  logic [1:0] grant_n, cand;
  logic ptr, ptr_n, gi, win, grdy, done_n;
  logic [7:0] gdata, wdata;
  logic [CNT_W-1:0] cnt, cnt_n, drop_n;
  function automatic logic is_sync(input logic [7:0] b);
    return b == 8'h47 || b == 8'hB8;
  endfunction
  assign gi = bus.grant[1];
  assign gdata = gi ? bus.in_data1 : bus.in_data0;
  assign grdy = bus.in_rdy[gi];
  assign cand = bus.in_rdy & bus.ch_en;
  assign win = &cand ? ptr : cand[1];
  assign wdata = win ? bus.in_data1 : bus.in_data0;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state;
    grant_n = bus.grant;
    ptr_n = ptr;
    cnt_n = cnt;
    drop_n = bus.drop_cnt;
    done_n = 1'b0;
    bus.in_acpt = 2'b00;
    bus.out_rdy = 1'b0;
    bus.out_data = 8'h00;
    if (state == IDLE) begin
      if (|cand) begin
        grant_n = win ? 2'b10 : 2'b01;
        state_n = is_sync(wdata) ? FWD : DROP;
      end
    end else if (state == DROP) begin
      if (!bus.ch_en[gi]) begin
        state_n = IDLE;
        grant_n = 2'b00;
      end else if (grdy && is_sync(gdata)) begin
        state_n = FWD;
      end else begin
        bus.in_acpt = bus.grant;
        drop_n = (grdy && !(&bus.drop_cnt)) ? bus.drop_cnt + 1'b1 : bus.drop_cnt;
      end
    end else begin
      bus.out_rdy = grdy;
      bus.out_data = grdy ? gdata : 8'h00;
      bus.in_acpt = bus.out_acpt ? bus.grant : 2'b00;
      if (grdy && bus.out_acpt) begin
        if (cnt == CNT_W'(PKT_LEN - 1)) begin
          state_n = IDLE;
          grant_n = 2'b00;
          cnt_n = '0;
          ptr_n = ~gi;
          done_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.grant <= 2'b00;
      ptr <= 1'b0;
      cnt <= '0;
      bus.drop_cnt <= '0;
      bus.pkt_done <= 1'b0;
    end else begin
      bus.grant <= grant_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      bus.drop_cnt <= drop_n;
      bus.pkt_done <= done_n;
    end
endmodule

// File: tb/tb_pkt_arbiter.sv
// tb_pkt_arbiter: directed tests against a stream-level model of sync alignment and round-robin grants.
module tb_pkt_arbiter;
  localparam int PKT_LEN = 204;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  pkt_arbiter_if #(.CNT_W(8)) ifc ();
  pkt_arbiter #(.PKT_LEN(PKT_LEN), .CNT_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(ifc));
  int nvec = 0, nerr = 0;
  logic [7:0] sq0[$], sq1[$], mq0[$], mq1[$];
  int pkt_ch[$];
  int pos, pkts, busy_cyc, salt = 0;
  logic [7:0] mdrop, first_byte;
  logic mptr, mch, pd_exp, eg_valid, tmode, tog, hs0, hs1;
  logic [1:0] eg;
  function automatic logic is_sync(input logic [7:0] b);
    return b == 8'h47 || b == 8'hB8;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push(input int c, input logic [7:0] b);
    if (c == 1) begin sq1.push_back(b); mq1.push_back(b); end
    else begin sq0.push_back(b); mq0.push_back(b); end
  endtask
  task automatic load(input int c, input int junk, input int npk, input logic [7:0] sync);
    for (int i = 0; i < junk; i++) push(c, 8'h10 + 8'(i % 16));
    for (int p = 0; p < npk; p++)
      for (int i = 0; i < PKT_LEN; i++)
        push(c, i == 0 ? sync : 8'(i * 7 + c * 29 + p * 13 + salt));
    salt++;
  endtask
  task automatic mreset();
    pos = 0; pkts = 0; busy_cyc = 0; mdrop = 8'h00; mptr = 1'b0; mch = 1'b0;
    pd_exp = 1'b0; eg_valid = 1'b0; tmode = 1'b0; tog = 1'b0;
    pkt_ch.delete(); sq0.delete(); sq1.delete(); mq0.delete(); mq1.delete();
    ifc.ch_en = 2'b11;
  endtask
  task automatic model_start(input logic c);
    int n = 0;
    int t;
    if (c) while (mq1.size() > 0 && !is_sync(mq1[0])) begin void'(mq1.pop_front()); n++; end
    else while (mq0.size() > 0 && !is_sync(mq0[0])) begin void'(mq0.pop_front()); n++; end
    t = int'(mdrop) + n;
    mdrop = t > 255 ? 8'hFF : 8'(t);
    mch = c;
    pkt_ch.push_back(c ? 1 : 0);
    chk("drop_cnt_at_start", 32'(ifc.drop_cnt), 32'(mdrop));
  endtask
  task automatic step();
    logic [1:0] cand;
    logic [7:0] exp_b;
    ifc.in_rdy[0] = sq0.size() > 0;
    ifc.in_rdy[1] = sq1.size() > 0;
    ifc.in_data0 = sq0.size() > 0 ? sq0[0] : 8'h00;
    ifc.in_data1 = sq1.size() > 0 ? sq1[0] : 8'h00;
    ifc.out_acpt = tmode ? tog : 1'b1;
    tog = ~tog;
    @(negedge clk);
    chk("grant_not_both", 32'(&ifc.grant), 32'd0);
    chk("acpt_only_granted", 32'(ifc.in_acpt & ~ifc.grant), 32'd0);
    chk("busy", 32'(ifc.busy), 32'(|ifc.grant));
    chk("pkt_done", 32'(ifc.pkt_done), 32'(pd_exp));
    pd_exp = 1'b0;
    if (eg_valid) chk("grant_pick", 32'(ifc.grant), 32'(eg));
    eg_valid = 1'b0;
    if (ifc.grant == 2'b00) begin
      cand = ifc.in_rdy & ifc.ch_en;
      eg = cand == 2'b11 ? (mptr ? 2'b10 : 2'b01) : cand;
      eg_valid = 1'b1;
    end else busy_cyc++;
    if (!ifc.out_rdy) chk("out_data_zero", 32'(ifc.out_data), 32'd0);
    else begin
      chk("passthru", 32'(ifc.out_data), 32'(ifc.grant[1] ? ifc.in_data1 : ifc.in_data0));
      chk("acpt_mirror", 32'(ifc.in_acpt), 32'(ifc.out_acpt ? ifc.grant : 2'b00));
    end
    hs0 = ifc.in_rdy[0] & ifc.in_acpt[0];
    hs1 = ifc.in_rdy[1] & ifc.in_acpt[1];
    if (ifc.out_rdy && ifc.out_acpt) begin
      if (pos == 0) begin model_start(ifc.grant[1]); first_byte = ifc.out_data; end
      if ((mch ? mq1.size() : mq0.size()) == 0) chk("model_empty", 32'(ifc.out_data), 32'hFFFF);
      else begin
        exp_b = mch ? mq1.pop_front() : mq0.pop_front();
        chk("byte", 32'(ifc.out_data), 32'(exp_b));
      end
      pos++;
      if (pos == PKT_LEN) begin
        pos = 0; pkts++; pd_exp = 1'b1; mptr = ~mch; eg = 2'b00; eg_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (hs0 && sq0.size() > 0) void'(sq0.pop_front());
    if (hs1 && sq1.size() > 0) void'(sq1.pop_front());
  endtask
  task automatic run_pkts(input int n);
    int start = pkts;
    int k = 0;
    while (pkts - start < n && k < 1200 * n) begin step(); k++; end
    chk("pkt_timeout", 32'(pkts - start), 32'(n));
    step();
  endtask
  task automatic run_to_pos(input int target);
    int k = 0;
    while (pos != target && k < 1000) begin step(); k++; end
    chk("pos_timeout", 32'(pos), 32'(target));
  endtask
  task automatic apply_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mreset();
  endtask
  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_in_acpt"}, 32'(ifc.in_acpt), 32'd0);
    chk({nm, "_out_rdy"}, 32'(ifc.out_rdy), 32'd0);
    chk({nm, "_out_data"}, 32'(ifc.out_data), 32'd0);
    chk({nm, "_grant"}, 32'(ifc.grant), 32'd0);
    chk({nm, "_busy"}, 32'(ifc.busy), 32'd0);
    chk({nm, "_pkt_done"}, 32'(ifc.pkt_done), 32'd0);
    chk({nm, "_drop_cnt"}, 32'(ifc.drop_cnt), 32'd0);
  endtask
  initial begin
    ifc.ch_en = 2'b11; ifc.in_rdy = 2'b00; ifc.in_data0 = 8'h00; ifc.in_data1 = 8'h00;
    ifc.out_acpt = 1'b1;
    mreset();
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    load(0, 0, 1, 8'h47);
    run_pkts(1);
    chk("t1_fwd_cycles", 32'(busy_cyc), 32'd204);
    chk("t1_grant_idle", 32'(ifc.grant), 32'd0);
    chk("t1_first", 32'(first_byte), 32'h47);
    apply_reset();
    load(0, 0, 2, 8'h47);
    load(1, 0, 2, 8'hB8);
    run_pkts(3);
    chk("t2_npkts", 32'(pkt_ch.size()), 32'd3);
    if (pkt_ch.size() >= 3) begin
      chk("t2_order0", 32'(pkt_ch[0]), 32'd0);
      chk("t2_order1", 32'(pkt_ch[1]), 32'd1);
      chk("t2_order2", 32'(pkt_ch[2]), 32'd0);
    end
    apply_reset();
    load(1, 5, 1, 8'hB8);
    run_pkts(1);
    chk("t3_drop5", 32'(ifc.drop_cnt), 32'd5);
    chk("t3_first", 32'(first_byte), 32'hB8);
    chk("t3_ch1", 32'(pkt_ch.size() > 0 ? pkt_ch[0] : -1), 32'd1);
    load(0, 260, 1, 8'h47);
    run_pkts(1);
    chk("t3_drop_sat", 32'(ifc.drop_cnt), 32'hFF);
    apply_reset();
    load(0, 0, 1, 8'h47);
    tmode = 1'b1;
    tog = 1'b1;
    run_pkts(1);
    chk("t4_fwd_cycles", 32'(busy_cyc), 32'd408);
    apply_reset();
    load(0, 3, 1, 8'h47);
    load(1, 0, 1, 8'hB8);
    run_pkts(1);
    run_to_pos(100);
    chk("t5_mid_grant", 32'(ifc.grant), 32'b10);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("t5_async");
    apply_reset();
    load(0, 0, 1, 8'h47);
    load(1, 0, 1, 8'hB8);
    run_pkts(1);
    chk("t5_favour0", 32'(pkt_ch.size() > 0 ? pkt_ch[0] : -1), 32'd0);
    apply_reset();
    ifc.ch_en = 2'b01;
    load(0, 0, 2, 8'h47);
    load(1, 0, 2, 8'hB8);
    run_pkts(2);
    chk("t6_only0_a", 32'(pkt_ch.size() > 0 ? pkt_ch[0] : -1), 32'd0);
    chk("t6_only0_b", 32'(pkt_ch.size() > 1 ? pkt_ch[1] : -1), 32'd0);
    load(0, 0, 1, 8'h47);
    run_to_pos(50);
    ifc.ch_en = 2'b00;
    run_pkts(1);
    chk("t6_fwd_completes", 32'(pkts), 32'd3);
    step();
    chk("t6_idle_after", 32'(ifc.grant), 32'd0);
    apply_reset();
    ifc.ch_en = 2'b01;
    load(0, 10, 1, 8'h47);
    step();
    step();
    step();
    ifc.ch_en = 2'b00;
    step();
    step();
    chk("t6_abort_grant", 32'(ifc.grant), 32'd0);
    chk("t6_abort_busy", 32'(ifc.busy), 32'd0);
    chk("t6_abort_drops", 32'(ifc.drop_cnt), 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pkt_arbiter.md
Name: pkt_arbiter

Overview:
- Two-input packet-level arbiter feeding the interleaver's rdy/acpt byte input (`di_rdy`/`di_acpt`/`di`).
- Shares one interleaver between two transport-stream sources, switching only on packet boundaries. Grants round-robin.
- Aligns each granted packet to a sync byte (8'h47 or 8'hB8) and discards bytes ahead of a sync.
- Forwards exactly PKT_LEN bytes per grant, so the downstream 204-byte framing is never broken.

Parameters:
- PKT_LEN, 204, bytes forwarded per granted packet, sync byte included; legal range 2..255.
- CNT_W, 8, width of the byte counter and of drop_cnt.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- ch_en  in  2  per-channel enable; a disabled channel is never granted
- in_rdy  in  2  source rdy, one bit per channel
- in_acpt  out  2  source acpt, one bit per channel
- in_data0  in  8  channel 0 byte
- in_data1  in  8  channel 1 byte
- out_rdy  out  1  to interleaver di_rdy
- out_acpt  in  1  from interleaver di_acpt
- out_data  out  8  to interleaver di
- grant  out  2  one-hot active channel; 0 when idle
- busy  out  1  state != IDLE
- pkt_done  out  1  one-cycle pulse after the last byte of a packet is accepted
- drop_cnt  out  CNT_W  saturating count of discarded bytes

Behaviour:
- Handshake:
  - A transfer occurs on a cycle where rdy and acpt are both 1.
  - A source holds data stable while rdy=1.
  - Handshakes are combinational pass-through; no data buffering.
- Reset (asynchronous, any time, including mid-packet):
  - state=IDLE, grant=0, byte count=0, drop_cnt=0, pkt_done=0.
  - Round-robin pointer favours channel 0.
  - Outputs: in_acpt=0, out_rdy=0, out_data=0.
- State IDLE:
  - in_acpt=0, out_rdy=0.
  - Candidates are channels with in_rdy & ch_en.
  - If both are candidates, the channel not granted last wins (pointer).
  - The winner's byte is inspected without accepting it:
    - sync byte -> FWD next cycle.
    - otherwise -> DROP next cycle.
  - grant is registered on that same edge.
- State DROP:
  - in_acpt[g]=1, out_rdy=0; each handshake on channel g discards one byte and increments drop_cnt.
  - drop_cnt saturates at all-ones.
  - A sync byte presented on g with in_rdy[g]=1 is NOT accepted: in_acpt[g] is 0 that cycle and state -> FWD.
  - If ch_en[g] drops: -> IDLE, grant cleared, pointer unchanged.
- State FWD:
  - out_rdy=in_rdy[g], out_data=selected in_data, in_acpt[g]=out_acpt.
  - The other channel's acpt stays 0.
  - Each out handshake increments the byte count.
  - The handshake at count==PKT_LEN-1 ends the packet:
    - -> IDLE, count=0, grant=0.
    - Pointer moves to the other channel.
    - pkt_done=1 on the following cycle.
  - ch_en is ignored in FWD; the packet always completes.
  - The first FWD byte is always the sync byte. Sync values appearing later in the packet are payload and are forwarded.
- out_data is 0 whenever out_rdy=0.
- Latency:
  - Grant decision: one cycle (IDLE -> FWD).
  - Turnaround: minimum one idle cycle between packets; no back-to-back grant without an IDLE cycle.
  - The byte path itself has zero cycles of latency.
- Fairness: with both channels continuously ready, grants alternate 0,1,0,1.
- grant is one-hot or zero; never 2'b11.

Test Plan:
1. Channel 0 alone, first byte 8'h47, 204 bytes with out_acpt=1 -> FWD for 204 cycles, 204 bytes appear in order on out_data, pkt_done pulses once, grant returns to 0.
2. Both channels ready with sync at the head, out_acpt=1 -> packets alternate ch0, ch1, ch0; each packet is exactly 204 bytes; in_acpt never asserts for both channels at once.
3. Channel 1 presents 5 junk bytes then 8'hB8 -> DROP accepts exactly 5, drop_cnt=5, 8'hB8 is the first forwarded byte, 204 bytes total.
4. out_acpt toggling 1,0 every cycle -> in_acpt[g] mirrors it; packet completes after 408 cycles with no lost or duplicated bytes.
5. reset_n pulsed low at byte 100 of a packet -> outputs go to reset values immediately; the next packet starts from IDLE with count 0 and channel 0 favoured.
6. ch_en=2'b01 with both channels ready -> only channel 0 is granted. Clearing ch_en[0] mid-FWD still completes the packet; in DROP it aborts to IDLE.
